// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM port arbiter.
//   arb_state_t : arbiter FSM states
//   CNT_W       : width of each per-core grant counter
//   MAX_CORES   : largest supported core count (sizes rr_next's request vector)
//   PTR_W       : width of a core index / round-robin pointer
//   rr_next()   : round-robin winner search starting just after ptr
package dram_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RD_WAIT} arb_state_t;

  localparam int CNT_W     = 16;
  localparam int MAX_CORES = 8;
  localparam int PTR_W     = 3;

  // Returns the first set bit of req searching from ptr+1 upward and
  // wrapping at n. When req is empty the result is ptr; the caller gates
  // use of the index with its own valid flag.
  function automatic logic [PTR_W-1:0] rr_next(input logic [MAX_CORES-1:0] req,
                                               input logic [PTR_W-1:0]     ptr,
                                               input int                   n);
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;
    int               pos;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_CORES; k++) begin
      if (k <= n) begin
        pos = (int'(ptr) + k) % n;
        idx = PTR_W'(pos);
        if (!found && req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Core-side bus of the DRAM arbiter.
//   core_rd/core_wr : per-core level requests (driven by the core array)
//   core_addr       : packed addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata      : packed write data, core i at [i*DATA_W +: DATA_W]
//   core_ack        : one-hot single-cycle acknowledge (driven by arbiter)
//   core_rdata      : shared read data, valid while a read owner's ack is high
// Handshake: a core raises core_rd or core_wr and holds it, with address and
// data stable, until it sees its core_ack pulse; it must drop the request in
// that ack cycle. A write ack means the DRAM write strobe is being issued in
// that cycle; a read ack means core_rdata carries the result in that cycle.
interface dram_arb_core_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
);
  logic [NUM_CORES-1:0]        core_rd;
  logic [NUM_CORES-1:0]        core_wr;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic [DATA_W-1:0]           core_rdata;

  modport master (output core_rd, core_wr, core_addr, core_wdata,
                  input  core_ack, core_rdata);
  modport slave  (input  core_rd, core_wr, core_addr, core_wdata,
                  output core_ack, core_rdata);
endinterface

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin priority search.
//   req   : request vector, one bit per core
//   ptr   : index of the most recently granted core
//   valid : at least one request present
//   idx   : winning core index (first request after ptr, wrapping)
module rr_picker
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 valid,
  output logic [PTR_W-1:0]     idx
);

  logic [MAX_CORES-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_CORES-1:0] = req;
  end

  assign valid = |req;
  assign idx   = rr_next(req_ext, ptr, NUM_CORES);

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among NUM_CORES cores.
//   clk, rst   : clock and synchronous active-low reset
//   core       : core-side bus (dram_arb_core_if.slave)
//   dram_addr, dram_wdata, dram_wrEn, dram_rdEn : registered DRAM controls
//   dram_rdata : DRAM read data, valid RD_LAT cycles after dram_rdEn
//   busy       : high whenever the FSM is not IDLE
//   grant_cnt  : per-core 16-bit saturating grant counters, core i at
//                [i*16 +: 16]; only generated when DRAM_ARB_PERF_EN is
//                defined, otherwise tied to 0
//   state_dbg  : current FSM state
// One transfer is in flight at a time. Writes take IDLE->WRITE (ack in the
// WRITE cycle); reads take IDLE->READ->RD_WAIT x RD_LAT->IDLE (ack in the
// first IDLE cycle).
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  dram_arb_core_if.slave             core,
  output logic [ADDR_W-1:0]          dram_addr,
  output logic [DATA_W-1:0]          dram_wdata,
  output logic                       dram_wrEn,
  output logic                       dram_rdEn,
  input  logic [DATA_W-1:0]          dram_rdata,
  output logic                       busy,
  output logic [NUM_CORES*CNT_W-1:0] grant_cnt,
  output arb_state_t                 state_dbg
);

  arb_state_t           state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [NUM_CORES-1:0] owner_q;
  logic [NUM_CORES-1:0] ack_q;
  logic [2:0]           wait_q;
  logic [DATA_W-1:0]    rdata_q;

  logic [NUM_CORES-1:0] req;
  logic                 win_valid;
  logic [PTR_W-1:0]     win_idx;
  logic [NUM_CORES-1:0] win_oh;
  logic                 win_wr;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;

  // A read owner is acked in an IDLE cycle while its level request may
  // still be high; exclude it so it cannot be served twice.
  assign req = (core.core_rd | core.core_wr) & ~(ack_q & {NUM_CORES{state_q == IDLE}});

  rr_picker #(.NUM_CORES(NUM_CORES)) u_picker (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (win_valid),
    .idx   (win_idx)
  );

  assign win_oh = NUM_CORES'(1) << win_idx;

  // Winner's operands; a set core_wr wins over core_rd on the same core.
  always_comb begin
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_oh[i]) begin
        win_wr    = core.core_wr[i];
        win_addr  = core.core_addr[i*ADDR_W +: ADDR_W];
        win_wdata = core.core_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = win_wr ? WRITE : READ;
      WRITE:   state_d = IDLE;
      READ:    state_d = RD_WAIT;
      RD_WAIT: if (wait_q <= 3'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and ack are pulses: cleared every cycle unless set below. They
  // are loaded one edge early so they are visible in the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PTR_W'(NUM_CORES - 1);
      owner_q    <= '0;
      ack_q      <= '0;
      wait_q     <= '0;
      rdata_q    <= '0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_wrEn  <= 1'b0;
      dram_rdEn  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dram_wrEn <= 1'b0;
      dram_rdEn <= 1'b0;
      ack_q     <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            owner_q    <= win_oh;
            rr_ptr_q   <= win_idx;
            dram_addr  <= win_addr;
            dram_wdata <= win_wdata;
            if (win_wr) begin
              dram_wrEn <= 1'b1;
              ack_q     <= win_oh;
            end else begin
              dram_rdEn <= 1'b1;
            end
          end
        end
        READ: wait_q <= 3'(RD_LAT);
        RD_WAIT: begin
          wait_q <= wait_q - 3'd1;
          if (wait_q <= 3'd1) begin
            rdata_q <= dram_rdata;
            ack_q   <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign core.core_ack   = ack_q;
  assign core.core_rdata = rdata_q;
  assign busy            = (state_q != IDLE);
  assign state_dbg       = state_q;

`ifdef DRAM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_q [NUM_CORES];
  logic             grant;

  assign grant = (state_q == IDLE) && win_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (win_oh[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              clk;
  logic              rst;
  logic [AW-1:0]     dram_addr;
  logic [DW-1:0]     dram_wdata;
  logic              dram_wrEn;
  logic              dram_rdEn;
  logic [DW-1:0]     dram_rdata;
  logic              busy;
  logic [NC*16-1:0]  grant_cnt;
  arb_state_t        state_dbg;

  dram_arb_core_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) cif ();

  dram_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (cif),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_wrEn  (dram_wrEn),
    .dram_rdEn  (dram_rdEn),
    .dram_rdata (dram_rdata),
    .busy       (busy),
    .grant_cnt  (grant_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model with one cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (dram_wrEn) mem[dram_addr[7:0]] <= dram_wdata;
    if (dram_rdEn) dram_rdata <= mem[dram_addr[7:0]];
  end

  // scoreboard
  int            n_checks = 0;
  int            n_errs   = 0;
  logic [1:0]    exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: everything happens at the negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cif.core_addr[i*AW +: AW]  = a;
    cif.core_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [1:0] e;
    int         budget;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[5]          = 8'd35;
    mem[7]          = 8'h77;
    dram_rdata      = '0;
    rst             = 1'b0;
    cif.core_rd     = '0;
    cif.core_wr     = 4'b1111;
    cif.core_addr   = '0;
    cif.core_wdata  = '0;
    for (int i = 0; i < NC; i++) set_core(i, 16'h0100 + AW'(i), 8'h10 + DW'(i));

    // reset held for two edges with all cores requesting
    tick();
    tick();
    check_eq("rst_wrEn",  dram_wrEn, 0);
    check_eq("rst_rdEn",  dram_rdEn, 0);
    check_eq("rst_ack",   cif.core_ack, 0);
    check_eq("rst_addr",  dram_addr, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_rdata", cif.core_rdata, 0);
    check_eq("rst_state", state_dbg, IDLE);
    check_eq("rst_cnt",   grant_cnt, 0);

    // round robin: all four hold writes; expect 0,1,2,3,0
    rst = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (cif.core_ack != 0) begin
        e = exp_q.pop_front();
        check_eq("rr_ack",   cif.core_ack, 4'b0001 << e);
        check_eq("rr_addr",  dram_addr, 16'h0100 + 16'(e));
        check_eq("rr_wdata", dram_wdata, 8'h10 + 8'(e));
        check_eq("rr_wrEn",  dram_wrEn, 1);
        if (exp_q.size() == 0) cif.core_wr = '0;
      end
    end
    check_eq("rr_remaining", exp_q.size(), 0);
    tick();
    check_eq("rr_idle", state_dbg, IDLE);
    check_eq("rr_busy", busy, 0);

    // single write from core 2
    set_core(2, 16'h0010, 8'h23);
    cif.core_wr = 4'b0100;
    tick();
    check_eq("wr_wrEn",  dram_wrEn, 1);
    check_eq("wr_rdEn",  dram_rdEn, 0);
    check_eq("wr_addr",  dram_addr, 16'h0010);
    check_eq("wr_wdata", dram_wdata, 8'h23);
    check_eq("wr_ack",   cif.core_ack, 4'b0100);
    check_eq("wr_busy",  busy, 1);
    cif.core_wr = '0;
    tick();
    check_eq("wr_done_wrEn", dram_wrEn, 0);
    check_eq("wr_done_ack",  cif.core_ack, 0);
    check_eq("wr_done_state", state_dbg, IDLE);

    // single read from core 1, request held through its ack cycle
    set_core(1, 16'h0005, 8'h00);
    cif.core_rd = 4'b0010;
    tick();
    check_eq("rd_rdEn",  dram_rdEn, 1);
    check_eq("rd_addr",  dram_addr, 16'h0005);
    check_eq("rd_state", state_dbg, READ);
    check_eq("rd_ack0",  cif.core_ack, 0);
    tick();
    check_eq("rd_wait_rdEn",  dram_rdEn, 0);
    check_eq("rd_wait_state", state_dbg, RD_WAIT);
    check_eq("rd_wait_ack",   cif.core_ack, 0);
    tick();
    check_eq("rd_ack",       cif.core_ack, 4'b0010);
    check_eq("rd_rdata",     cif.core_rdata, 8'd35);
    check_eq("rd_ack_state", state_dbg, IDLE);
    tick();
    check_eq("rd_mask_state", state_dbg, IDLE);
    check_eq("rd_mask_rdEn",  dram_rdEn, 0);
    check_eq("rd_mask_ack",   cif.core_ack, 0);
    check_eq("rd_hold_rdata", cif.core_rdata, 8'd35);
    cif.core_rd = '0;

    // core 3 asserts rd and wr together: write wins
    set_core(3, 16'h0042, 8'h5A);
    cif.core_rd = 4'b1000;
    cif.core_wr = 4'b1000;
    tick();
    check_eq("both_state", state_dbg, WRITE);
    check_eq("both_wrEn",  dram_wrEn, 1);
    check_eq("both_rdEn",  dram_rdEn, 0);
    check_eq("both_ack",   cif.core_ack, 4'b1000);
    check_eq("both_addr",  dram_addr, 16'h0042);
    check_eq("both_wdata", dram_wdata, 8'h5A);
    tick();
    check_eq("both_after_state", state_dbg, IDLE);
    check_eq("both_after_ack",   cif.core_ack, 0);
    cif.core_rd = '0;
    cif.core_wr = '0;
    tick();
    check_eq("both_idle_wrEn", dram_wrEn, 0);
    check_eq("both_idle_rdEn", dram_rdEn, 0);

    // reset in the middle of a read from core 0
    set_core(0, 16'h0007, 8'h00);
    cif.core_rd = 4'b0001;
    tick();
    check_eq("abort_read_state", state_dbg, READ);
    tick();
    check_eq("abort_wait_state", state_dbg, RD_WAIT);
    rst = 1'b0;
    tick();
    check_eq("abort_ack",   cif.core_ack, 0);
    check_eq("abort_state", state_dbg, IDLE);
    check_eq("abort_busy",  busy, 0);
    check_eq("abort_rdata", cif.core_rdata, 0);
    check_eq("abort_cnt",   grant_cnt, 0);
    rst = 1'b1;
    cif.core_rd = '0;
    tick();
    check_eq("abort_after_ack",   cif.core_ack, 0);
    check_eq("abort_after_state", state_dbg, IDLE);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM port between NUM_CORES matrix-multiply cores.
- Each core presents a read or write request on its DRAM side. The arbiter grants one request at a time in round-robin order.
- It drives the DRAM address, write-data and write-enable, and returns read data with a one-cycle valid pulse.
- Sits between the core array and the DRAM macro in the multi-core top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 16, DRAM address width (matches core ar_out).
- DATA_W, 8, DRAM data width.
- RD_LAT, 1, DRAM read latency in cycles from dram_rdEn to valid dram_rdata (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- core_rd  input  NUM_CORES  per-core read request, level.
- core_wr  input  NUM_CORES  per-core write request, level.
- core_addr  input  NUM_CORES*ADDR_W  packed addresses; core i at [i*ADDR_W +: ADDR_W].
- core_wdata  input  NUM_CORES*DATA_W  packed write data.
- core_ack  output  NUM_CORES  one-hot, 1-cycle pulse: write done, or read data valid.
- core_rdata  output  DATA_W  read data, shared; valid only while core_ack of a read owner is high.
- dram_addr  output  ADDR_W  DRAM address.
- dram_wdata  output  DATA_W  DRAM write data.
- dram_wrEn  output  1  DRAM write strobe.
- dram_rdEn  output  1  DRAM read strobe.
- dram_rdata  input  DATA_W  DRAM read data.
- busy  output  1  high in every state except IDLE.
- grant_cnt  output  NUM_CORES*16  per-core grant counters (optional feature).

Behaviour:
- Reset values (rst=0 at a clock edge): all outputs 0, state IDLE, rr_ptr = NUM_CORES-1 so core 0 has first priority, wait counter 0.
- Reset mid-operation aborts any in-flight transfer; no ack is issued for it.
- FSM states: IDLE, WRITE, READ, RD_WAIT.
- IDLE:
  - req[i] = core_rd[i] | core_wr[i], masked for the core acked in this same cycle.
  - Winner = first set bit searching from rr_ptr+1 upward, wrapping at NUM_CORES.
  - Register owner, addr and wdata; set rr_ptr = owner.
  - Go to WRITE if core_wr[owner], else READ. Stay in IDLE if there is no request.
- WRITE (1 cycle): dram_wrEn=1, dram_addr/dram_wdata from the owner; core_ack[owner]=1 in this same cycle; next state IDLE.
- READ (1 cycle): dram_rdEn=1, dram_addr from the owner; next state RD_WAIT; wait counter loads RD_LAT.
- RD_WAIT:
  - Counter decrements each cycle.
  - At 0, capture dram_rdata into core_rdata; in the next cycle core_ack[owner]=1 and the state returns to IDLE.
  - Net latency: request seen at cycle t, READ at t+1, ack at t+2+RD_LAT.
- Ack-cycle masking: in any cycle where core_ack[i]=1 and the state is IDLE, core i's request is excluded from arbitration. This prevents double service while the core drops its level request; a core must deassert in the ack cycle.
- Simultaneous core_rd and core_wr on one core: write wins; the read bit is ignored for that grant.
- dram_addr, dram_wdata and the strobes are registered outputs. Strobes are 0 in IDLE and RD_WAIT.
- core_rdata holds its last captured value until the next read capture.
- One transfer is in flight at a time; no pipelining.

Optional Feature:
- Macro DRAM_ARB_PERF_EN.
- Defined: grant_cnt[i] is a 16-bit counter that increments on every grant to core i, saturates at 16'hFFFF, and is cleared by reset.
- Undefined: grant_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package dram_arb_pkg holds:
  - state enum arb_state_t {IDLE, WRITE, READ, RD_WAIT};
  - constant CNT_W=16;
  - function rr_next(req, ptr) returning the winner index.
- One sub-module, rr_picker: combinational round-robin priority search, NUM_CORES parameterised, outputs a valid flag and index.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with core_wr=4'b1111 -> all outputs 0, no dram_wrEn. Release -> first grant goes to core 0.
- Single write: core 2 wr addr=16'h0010, wdata=8'h23 -> next cycle dram_wrEn=1, dram_addr=0010, dram_wdata=23, core_ack=4'b0100 in the same cycle.
- Single read, RD_LAT=1: core 1 rd addr=16'h0005, DRAM returns 8'd35 -> dram_rdEn at t+1, core_ack=4'b0010 with core_rdata=35 at t+3.
- Round robin: all 4 cores hold writes -> grant order 0,1,2,3,0; no core is granted twice while another is waiting.
- Mask and priority: core 3 asserts core_rd and core_wr together -> a write is performed. Core 3 keeps its request high in the ack cycle -> it is not re-granted in that cycle.
- Reset mid-read: rst=0 during RD_WAIT -> no core_ack, state IDLE, counters 0 (PERF on).
